// File: rtl/uart_rx_frame_if.sv
// Receive-word handshake bundle: data, flags, valid/ready.
// master = receiver (drives word+flags), slave = consumer (drives ready).
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_data_valid;
  logic                 rx_data_ready;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_overrun;

  modport master (
    output rx_data,
    output rx_data_valid,
    output rx_parity_err,
    output rx_frame_err,
    output rx_overrun,
    input  rx_data_ready
  );

  modport slave (
    input  rx_data,
    input  rx_data_valid,
    input  rx_parity_err,
    input  rx_frame_err,
    input  rx_overrun,
    output rx_data_ready
  );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receiver: N data bits, opt. parity, 1/2 stops, 3-sample vote.
// Ports: clk, rst_n, rx_pin (async serial in), rx (word handshake).
module uart_rx_frame #(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_pin,
  uart_rx_frame_if.master   rx
);
  localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int HALF  = CYCLE / 2;
  localparam int BW    = $clog2(DATA_BITS) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic                 sync1_q, rx_s_q, rx_p_q;
  logic [2:0]           state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           smp_q, smp_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 stop2_q, stop2_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 operr_q, operr_d;
  logic                 oferr_q, oferr_d;
  logic                 ovr_q, ovr_d;

  logic at_res, at_end, bit_v, par_x, last_stop, done, ferr_fin;

  assign at_res    = cnt_q == 16'(HALF + 1);
  assign at_end    = cnt_q == 16'(CYCLE - 1);
  // third vote is the live sample at the resolve point
  assign bit_v     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q)
                   | (smp_q[1] & rx_s_q);
  assign par_x     = ^shift_q ^ bit_v;
  assign last_stop = (STOP_BITS == 1) || stop2_q;
  assign ferr_fin  = ferr_q | ~bit_v;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    smp_d   = smp_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    stop2_d = stop2_q;
    done    = 1'b0;
    if (cnt_q == 16'(HALF - 1)) smp_d[0] = rx_s_q;
    if (cnt_q == 16'(HALF))     smp_d[1] = rx_s_q;
    if (at_end) cnt_d = '0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_p_q && !rx_s_q) begin
          state_d = S_START;
          bcnt_d  = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          stop2_d = 1'b0;
        end
      end
      S_START: begin
        if (at_res && bit_v) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (at_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (at_res) begin
          for (int i = 0; i < DATA_BITS; i++)
            if (bcnt_q == BW'(i)) shift_d[i] = bit_v;
        end
        if (at_end) begin
          if (bcnt_q == BW'(DATA_BITS - 1))
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          else
            bcnt_d = bcnt_q + BW'(1);
        end
      end
      S_PAR: begin
        if (at_res)
          perr_d = (PARITY == 1) ? ~par_x : par_x;
        if (at_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (at_res) begin
          if (!bit_v) ferr_d = 1'b1;
          // leave mid-bit so a back-to-back start edge is seen
          if (last_stop) begin
            done    = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else if (at_end) begin
          stop2_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    operr_d = operr_q;
    oferr_d = oferr_q;
    ovr_d   = ovr_q;
    if (done) begin
      if (!valid_q || rx.rx_data_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
        operr_d = (PARITY != 0) && perr_q;
        oferr_d = ferr_fin;
        ovr_d   = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx.rx_data_ready) begin
      valid_d = 1'b0;
      operr_d = 1'b0;
      oferr_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_p_q  <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      smp_q   <= 2'b11;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      stop2_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      operr_q <= 1'b0;
      oferr_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= rx_pin;
      rx_s_q  <= sync1_q;
      rx_p_q  <= rx_s_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      smp_q   <= smp_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      stop2_q <= stop2_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      operr_q <= operr_d;
      oferr_q <= oferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx.rx_data       = data_q;
  assign rx.rx_data_valid = valid_q;
  assign rx.rx_parity_err = operr_q;
  assign rx.rx_frame_err  = oferr_q;
  assign rx.rx_overrun    = ovr_q;
endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench: 8N1 instance (a) and 7E2 instance (b), CYCLE = 16 clocks.
// Table of frames plus hand sequences for glitch/overrun/reset.
module tb_uart_rx_frame;
  localparam int BIT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;

  always #5 clk = ~clk;

  uart_rx_frame_if #(.DATA_BITS(8)) ifa ();
  uart_rx_frame_if #(.DATA_BITS(7)) ifb ();

  uart_rx_frame #(
    .CLK_FRE(16), .BAUD_RATE(1000000),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .rx_pin(rx_a), .rx(ifa.master)
  );

  uart_rx_frame #(
    .CLK_FRE(16), .BAUD_RATE(1000000),
    .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .rx_pin(rx_b), .rx(ifb.master)
  );

  typedef struct {
    bit         w;
    logic [8:0] d;
    int         nb;
    int         par;
    bit         pflip;
    int         nstop;
    bit         stopv;
    int         gap;
    int         spike;
    logic [8:0] ed;
    bit         eperr;
    bit         eferr;
  } vec_t;

  vec_t vecs [9];

  int nvec = 0;
  int nerr = 0;

  // capture of delivered words
  int         nv_a = 0, nv_b = 0;
  logic [8:0] ld_a = '0, ld_b = '0;
  logic       lp_a = 1'b0, lp_b = 1'b0;
  logic       lf_a = 1'b0, lf_b = 1'b0;
  logic       lo_a = 1'b0, lo_b = 1'b0;

  always @(negedge clk) begin
    if (ifa.rx_data_valid) begin
      nv_a <= nv_a + 1;
      if (ifa.rx_data_ready) begin
        ld_a <= {1'b0, ifa.rx_data};
        lp_a <= ifa.rx_parity_err;
        lf_a <= ifa.rx_frame_err;
        lo_a <= ifa.rx_overrun;
      end
    end
    if (ifb.rx_data_valid) begin
      nv_b <= nv_b + 1;
      if (ifb.rx_data_ready) begin
        ld_b <= {2'b0, ifb.rx_data};
        lp_b <= ifb.rx_parity_err;
        lf_b <= ifb.rx_frame_err;
        lo_b <= ifb.rx_overrun;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic hold(input bit w, input logic v, input int n);
    if (w) rx_b = v;
    else   rx_a = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input vec_t v);
    logic p;
    hold(v.w, 1'b0, BIT);
    p = 1'b0;
    for (int i = 0; i < v.nb; i++) begin
      p = p ^ v.d[i];
      if (v.spike == i) begin
        hold(v.w, v.d[i], 8);
        hold(v.w, 1'b0, 1);
        hold(v.w, v.d[i], 7);
      end else begin
        hold(v.w, v.d[i], BIT);
      end
    end
    if (v.par != 0) begin
      if (v.par == 1) p = ~p;
      hold(v.w, p ^ v.pflip, BIT);
    end
    for (int s = 0; s < v.nstop; s++) hold(v.w, v.stopv, BIT);
    hold(v.w, 1'b1, BIT * v.gap);
  endtask

  function automatic vec_t mk(input bit w, input logic [8:0] d,
                              input bit pflip, input bit stopv,
                              input int gap, input int spike,
                              input bit eperr, input bit eferr);
    vec_t v;
    v.w = w; v.d = d;
    v.nb = w ? 7 : 8;
    v.par = w ? 2 : 0;
    v.nstop = w ? 2 : 1;
    v.pflip = pflip; v.stopv = stopv;
    v.gap = gap; v.spike = spike;
    v.ed = d; v.eperr = eperr; v.eferr = eferr;
    return v;
  endfunction

  initial begin
    int n0;
    vec_t v;
    vecs[0] = mk(1'b0, 9'h0A5, 1'b0, 1'b1, 1, -1, 1'b0, 1'b0);
    vecs[1] = mk(1'b1, 9'h035, 1'b0, 1'b1, 1, -1, 1'b0, 1'b0);
    vecs[2] = mk(1'b1, 9'h035, 1'b1, 1'b1, 1, -1, 1'b1, 1'b0);
    vecs[3] = mk(1'b0, 9'h03C, 1'b0, 1'b0, 2, -1, 1'b0, 1'b1);
    vecs[4] = mk(1'b0, 9'h001, 1'b0, 1'b1, 1, -1, 1'b0, 1'b0);
    vecs[5] = mk(1'b0, 9'h0FF, 1'b0, 1'b1, 1, 3, 1'b0, 1'b0);
    vecs[6] = mk(1'b1, 9'h07F, 1'b0, 1'b1, 1, -1, 1'b0, 1'b0);
    vecs[7] = mk(1'b0, 9'h000, 1'b0, 1'b1, 1, -1, 1'b0, 1'b0);
    vecs[8] = mk(1'b1, 9'h02A, 1'b0, 1'b0, 2, -1, 1'b0, 1'b1);

    ifa.rx_data_ready = 1'b1;
    ifb.rx_data_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_a", {ifa.rx_data_valid, ifa.rx_data, ifa.rx_parity_err,
                    ifa.rx_frame_err, ifa.rx_overrun}, 32'd0);
    chk("reset_b", {ifb.rx_data_valid, ifb.rx_data, ifb.rx_parity_err,
                    ifb.rx_frame_err, ifb.rx_overrun}, 32'd0);
    rst_n = 1'b1;
    repeat (2 * BIT) @(negedge clk);

    for (int k = 0; k < 9; k++) begin
      v = vecs[k];
      n0 = v.w ? nv_b : nv_a;
      send(v);
      if (v.w) begin
        chk($sformatf("v%0d_cnt", k), 32'(nv_b - n0), 32'd1);
        chk($sformatf("v%0d_data", k), 32'(ld_b), 32'(v.ed));
        chk($sformatf("v%0d_perr", k), 32'(lp_b), 32'(v.eperr));
        chk($sformatf("v%0d_ferr", k), 32'(lf_b), 32'(v.eferr));
        chk($sformatf("v%0d_ovr", k), 32'(lo_b), 32'd0);
      end else begin
        chk($sformatf("v%0d_cnt", k), 32'(nv_a - n0), 32'd1);
        chk($sformatf("v%0d_data", k), 32'(ld_a), 32'(v.ed));
        chk($sformatf("v%0d_perr", k), 32'(lp_a), 32'(v.eperr));
        chk($sformatf("v%0d_ferr", k), 32'(lf_a), 32'(v.eferr));
        chk($sformatf("v%0d_ovr", k), 32'(lo_a), 32'd0);
      end
    end

    // short low glitch: false start, no word
    n0 = nv_a;
    hold(1'b0, 1'b0, 4);
    hold(1'b0, 1'b1, 3 * BIT);
    chk("glitch_cnt", 32'(nv_a - n0), 32'd0);

    // overrun: three frames back-to-back while held
    ifa.rx_data_ready = 1'b0;
    send(mk(1'b0, 9'h011, 1'b0, 1'b1, 0, -1, 1'b0, 1'b0));
    send(mk(1'b0, 9'h022, 1'b0, 1'b1, 0, -1, 1'b0, 1'b0));
    send(mk(1'b0, 9'h033, 1'b0, 1'b1, 2, -1, 1'b0, 1'b0));
    chk("ovr_valid", 32'(ifa.rx_data_valid), 32'd1);
    chk("ovr_data", 32'(ifa.rx_data), 32'h11);
    chk("ovr_flag", 32'(ifa.rx_overrun), 32'd1);
    chk("ovr_ferr", 32'(ifa.rx_frame_err), 32'd0);
    ifa.rx_data_ready = 1'b1;
    @(negedge clk);
    ifa.rx_data_ready = 1'b0;
    @(negedge clk);
    chk("ovr_drop_valid", 32'(ifa.rx_data_valid), 32'd0);
    chk("ovr_drop_flag", 32'(ifa.rx_overrun), 32'd0);
    send(mk(1'b0, 9'h044, 1'b0, 1'b1, 2, -1, 1'b0, 1'b0));
    chk("ovr_next_valid", 32'(ifa.rx_data_valid), 32'd1);
    chk("ovr_next_data", 32'(ifa.rx_data), 32'h44);
    chk("ovr_next_flag", 32'(ifa.rx_overrun), 32'd0);
    ifa.rx_data_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ovr_drain", 32'(ifa.rx_data_valid), 32'd0);

    // reset in the middle of a frame, with a word held
    ifa.rx_data_ready = 1'b0;
    send(mk(1'b0, 9'h066, 1'b0, 1'b1, 2, -1, 1'b0, 1'b0));
    chk("held_data", {ifa.rx_data_valid, ifa.rx_data}, 32'h166);
    hold(1'b0, 1'b0, BIT);
    hold(1'b0, 1'b0, BIT);
    hold(1'b0, 1'b1, BIT);
    hold(1'b0, 1'b0, BIT / 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_a", {ifa.rx_data_valid, ifa.rx_data, ifa.rx_parity_err,
                     ifa.rx_frame_err, ifa.rx_overrun}, 32'd0);
    rx_a = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("postrst_idle", 32'(ifa.rx_data_valid), 32'd0);
    ifa.rx_data_ready = 1'b1;
    n0 = nv_a;
    send(mk(1'b0, 9'h081, 1'b0, 1'b1, 1, -1, 1'b0, 1'b0));
    chk("postrst_cnt", 32'(nv_a - n0), 32'd1);
    chk("postrst_data", 32'(ld_a), 32'h81);
    chk("postrst_flags", {29'd0, lp_a, lf_a, lo_a}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
